// File: rtl/cic_pkg.sv
// Shared CIC definitions used by the interpolator and decimator datapaths.
package cic_pkg;

  typedef int unsigned cic_stages_t;

  // Bit growth of an N-stage CIC with ratio r and differential delay m.
  function automatic int unsigned cic_out_width(input int unsigned width,
                                                input int unsigned n,
                                                input int unsigned r,
                                                input int unsigned m);
    return width + n * $clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// Valid/ready sample streams into and out of the CIC interpolator.
interface cic_interpolator_if
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned W_OUT = cic_out_width(8, 2, 4, 1)
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W_OUT-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/cic_integrator_stage.sv
// One wrap-around accumulator of the CIC integrator chain.
module cic_integrator_stage #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = acc_q + add_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at input rate, zero-stuff by R, integrator chain at output rate.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter cic_stages_t N_STAGES = 2,
  parameter int unsigned R        = 4,
  parameter int unsigned M        = 1
) (
  input logic               clk,
  input logic               rstn,
  cic_interpolator_if.slave bus
);

  localparam int unsigned W_OUT = cic_out_width(WIDTH, N_STAGES, R, M);
  localparam int unsigned PhW   = $clog2(R);

  logic [W_OUT-1:0] in_ext;
  logic [W_OUT-1:0] comb_result;
  logic [W_OUT-1:0] comb_q, comb_d;
  logic [W_OUT-1:0] ups;
  logic [PhW-1:0]   ph_q, ph_d;
  logic             cv_q, cv_d;
  logic             ov_q, ov_d;
  logic             ph_zero;
  logic             step;
  logic             accept;

  assign in_ext = {{(W_OUT - WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};

  // Comb stages: each delay line advances only when a sample is accepted.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    logic [W_OUT-1:0] c_in;
    logic [W_OUT-1:0] c_out;
    logic [W_OUT-1:0] dly_q [M];

    if (k == 0) begin : g_first
      assign c_in = in_ext;
    end else begin : g_chain
      assign c_in = g_comb[k-1].c_out;
    end

    assign c_out = c_in - dly_q[M-1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < M; i++) dly_q[i] <= '0;
      end else if (accept) begin
        dly_q[0] <= c_in;
        for (int i = 1; i < M; i++) dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign comb_result = g_comb[N_STAGES-1].c_out;

  always_comb begin
    ph_zero = (ph_q == '0);
    step    = (!ph_zero || cv_q) && (!ov_q || bus.out_ready);
    // Refill is allowed in the same cycle the held comb sample is consumed.
    bus.in_ready = rstn && (!cv_q || (step && ph_zero));
    accept  = bus.in_valid && bus.in_ready;
    ups     = ph_zero ? comb_q : '0;
  end

  always_comb begin
    comb_d = comb_q;
    cv_d   = cv_q;
    ph_d   = ph_q;
    ov_d   = ov_q;
    if (step && ph_zero) cv_d = 1'b0;
    if (accept) begin
      comb_d = comb_result;
      cv_d   = 1'b1;
    end
    if (step) begin
      ph_d = (ph_q == PhW'(R - 1)) ? '0 : ph_q + PhW'(1);
      ov_d = 1'b1;
    end else if (bus.out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      comb_q <= '0;
      cv_q   <= 1'b0;
      ph_q   <= '0;
      ov_q   <= 1'b0;
    end else begin
      comb_q <= comb_d;
      cv_q   <= cv_d;
      ph_q   <= ph_d;
      ov_q   <= ov_d;
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    logic [W_OUT-1:0] add;
    logic [W_OUT-1:0] acc;

    if (k == 0) begin : g_first
      assign add = ups;
    end else begin : g_chain
      assign add = g_int[k-1].acc;
    end

    cic_integrator_stage #(
      .W (W_OUT)
    ) u_stage (
      .clk   (clk),
      .rstn  (rstn),
      .en_i  (step),
      .add_i (add),
      .acc_o (acc)
    );
  end

  assign bus.out_data  = g_int[N_STAGES-1].acc;
  assign bus.out_valid = ov_q;

  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rstn)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data))
  );

endmodule

// File: tb/tb_cic_interpolator.sv
// Randomised self-checking bench for cic_interpolator against a whole-sequence CIC model.
module tb_cic_interpolator;
  import cic_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NS    = 2;
  localparam int unsigned R     = 4;
  localparam int unsigned M     = 1;
  localparam int unsigned W_OUT = cic_out_width(WIDTH, NS, R, M);

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  logic [WIDTH-1:0] stim  [$];
  logic [W_OUT-1:0] in_q  [$];
  logic [W_OUT-1:0] out_q [$];
  logic [W_OUT-1:0] exp_q [$];

  cic_interpolator_if #(.WIDTH(WIDTH), .W_OUT(W_OUT)) bus ();

  cic_interpolator #(
    .WIDTH    (WIDTH),
    .N_STAGES (NS),
    .R        (R),
    .M        (M)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = ($urandom_range(99) < 70);
      else                    bus.out_ready = 1'b0;
    end
  end

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rstn && bus.in_valid && bus.in_ready) in_q.push_back(W_OUT'(signed'(bus.in_data)));
    if (rstn && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
  end

  // Reference: difference the accepted samples N times, zero-stuff, then integrate N times.
  task automatic build_expected();
    int n_in = in_q.size();
    int nb = n_in * R;
    logic [W_OUT-1:0] y [];
    logic [W_OUT-1:0] t [];
    logic [W_OUT-1:0] s [];
    logic [W_OUT-1:0] acc;
    logic [W_OUT-1:0] prev;
    y = new[n_in];
    foreach (y[i]) y[i] = in_q[i];
    for (int k = 0; k < NS; k++) begin
      t = new[n_in];
      foreach (t[i]) t[i] = y[i] - ((i >= M) ? y[i-M] : '0);
      y = t;
    end
    s = new[nb];
    foreach (s[j]) s[j] = (j % R == 0) ? y[j / R] : '0;
    acc = '0;
    foreach (s[j]) begin
      acc  = acc + s[j];
      s[j] = acc;
    end
    // Later stages add the previous stage's value from before the current beat.
    for (int k = 1; k < NS; k++) begin
      acc = '0;
      foreach (s[j]) begin
        prev = s[j];
        s[j] = acc;
        acc  = acc + prev;
      end
    end
    exp_q = {};
    foreach (s[j]) exp_q.push_back(s[j]);
  endtask

  task automatic apply_reset();
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rdy_mode     = 0;
    repeat (2) @(posedge clk);
    #1;
    in_q  = {};
    out_q = {};
    rstn  = 1'b1;
  endtask

  task automatic drive_stream(input int unsigned vprob);
    int idx = 0;
    int guard = 0;
    while (idx < stim.size() && guard < 4000 && rstn) begin
      bus.in_valid = ($urandom_range(99) < vprob);
      bus.in_data  = stim[idx];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 4000) begin
      n_checks++;
      $display("FAIL drive_stream timeout: sent %0d of %0d samples", idx, stim.size());
    end
  endtask

  task automatic drain();
    int guard = 0;
    rdy_mode = 0;
    while (out_q.size() < in_q.size() * R && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_data !== '0) $display("FAIL reset out_data: got %0h want 0", bus.out_data);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL release in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL release out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse(input string name);
    int tri_exp [16] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [W_OUT-1:0] got;
    stim = {8'd1, 8'd0, 8'd0, 8'd0};
    drive_stream(100);
    drain();
    n_checks++;
    if (out_q.size() != 16) $display("FAIL %s beat count: got %0d want 16", name, out_q.size());
    else n_pass++;
    for (int j = 0; j < 16; j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== W_OUT'(tri_exp[j]))
        $display("FAIL %s beat %0d: got %0d want %0d", name, j, got, tri_exp[j]);
      else n_pass++;
    end
  endtask

  task automatic test_dc();
    logic [W_OUT-1:0] got;
    apply_reset();
    stim = {};
    repeat (10) stim.push_back(8'd3);
    drive_stream(100);
    drain();
    build_expected();
    n_checks++;
    if (out_q.size() != 40) $display("FAIL dc beat count: got %0d want 40", out_q.size());
    else n_pass++;
    for (int j = 4; j < 40; j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== W_OUT'(12)) $display("FAIL dc beat %0d: got %0d want 12", j, got);
      else n_pass++;
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== exp_q[j]) $display("FAIL dc model beat %0d: got %0h want %0h", j, got, exp_q[j]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W_OUT-1:0] held;
    logic [W_OUT-1:0] got;
    apply_reset();
    stim = {};
    repeat (20) stim.push_back(WIDTH'($urandom));
    fork
      drive_stream(100);
      begin
        repeat (15) @(posedge clk);
        @(negedge clk);
        rdy_mode      = 2;
        bus.out_ready = 1'b0;
        held          = bus.out_data;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (bus.out_data !== held)
            $display("FAIL bp out_data: got %0h want %0h", bus.out_data, held);
          else n_pass++;
          n_checks++;
          if (bus.out_valid !== 1'b1) $display("FAIL bp out_valid: got %b want 1", bus.out_valid);
          else n_pass++;
          n_checks++;
          if (bus.in_ready !== 1'b0) $display("FAIL bp in_ready: got %b want 0", bus.in_ready);
          else n_pass++;
        end
        rdy_mode      = 0;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    build_expected();
    n_checks++;
    if (out_q.size() != 80) $display("FAIL bp beat count: got %0d want 80", out_q.size());
    else n_pass++;
    for (int j = 0; j < exp_q.size(); j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== exp_q[j]) $display("FAIL bp model beat %0d: got %0h want %0h", j, got, exp_q[j]);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    logic [W_OUT-1:0] got;
    apply_reset();
    stim = {WIDTH'($urandom)};
    drive_stream(100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_q.size() != R) $display("FAIL underrun beats: got %0d want %0d", out_q.size(), R);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL underrun out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    stim = {WIDTH'($urandom)};
    drive_stream(100);
    drain();
    build_expected();
    n_checks++;
    if (out_q.size() != 2 * R) $display("FAIL resume beats: got %0d want %0d", out_q.size(), 2 * R);
    else n_pass++;
    for (int j = 0; j < exp_q.size(); j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== exp_q[j]) $display("FAIL resume beat %0d: got %0h want %0h", j, got, exp_q[j]);
      else n_pass++;
    end
  endtask

  task automatic test_stream(input string name, input bit alternate, input int unsigned vprob);
    logic [W_OUT-1:0] got;
    apply_reset();
    stim = {};
    for (int i = 0; i < 32; i++)
      stim.push_back(alternate ? ((i % 2 == 0) ? 8'h80 : 8'h7f) : WIDTH'($urandom));
    rdy_mode = 1;
    drive_stream(vprob);
    drain();
    build_expected();
    n_checks++;
    if (out_q.size() != 32 * R) $display("FAIL %s beat count: got %0d want %0d", name,
                                         out_q.size(), 32 * R);
    else n_pass++;
    for (int j = 0; j < exp_q.size(); j++) begin
      got = (j < out_q.size()) ? out_q[j] : 'x;
      n_checks++;
      if (got !== exp_q[j]) $display("FAIL %s beat %0d: got %0h want %0h", name, j, got, exp_q[j]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    stim = {};
    repeat (12) stim.push_back(WIDTH'($urandom));
    rdy_mode = 1;
    fork
      drive_stream(100);
      begin
        repeat (10) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst out_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.out_data !== '0) $display("FAIL midrst out_data: got %0h want 0", bus.out_data);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL midrst in_ready: got %b want 0", bus.in_ready);
        else n_pass++;
      end
    join
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    in_q  = {};
    out_q = {};
    rstn  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst release out_valid: got %b want 0",
                                         bus.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    test_impulse("midrst_impulse");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_backpressure();
    test_underrun();
    test_stream("wrap", 1'b1, 70);
    test_stream("random", 1'b0, 50);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
